// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared ALU: round-robin with a stall lock,
// plus a registered 1-entry response buffer tagged with the owning requester.
module alu_share_arb #(
   parameter int XLEN       = 32,
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            r0_valid_i,
   output logic            r0_ready_o,
   input  logic [4:0]      r0_aluc_i,
   input  logic [XLEN-1:0] r0_a_i,
   input  logic [XLEN-1:0] r0_b_i,
   input  logic            r1_valid_i,
   output logic            r1_ready_o,
   input  logic [4:0]      r1_aluc_i,
   input  logic [XLEN-1:0] r1_a_i,
   input  logic [XLEN-1:0] r1_b_i,
   output logic [4:0]      alu_aluc_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic            rsp_id_o,
   output logic [XLEN-1:0] rsp_result_o
);

   typedef struct packed {
      logic [4:0]      aluc;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } req_t;

   req_t [1:0] req;
   logic [1:0] vld;

   assign req[0] = '{aluc: r0_aluc_i, a: r0_a_i, b: r0_b_i};
   assign req[1] = '{aluc: r1_aluc_i, a: r1_a_i, b: r1_b_i};
   assign vld    = {r1_valid_i, r0_valid_i};

   logic            prio_q, prio_d;
   logic            lock_q, lock_d;
   logic            lock_id_q, lock_id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_id_q, rsp_id_d;
   logic [XLEN-1:0] rsp_result_q, rsp_result_d;

   logic       win_vld, win_id;
   logic       can_accept, fire;
   logic [1:0] rdy;

   // A locked winner only counts while it still asserts valid; a dropped
   // valid leaves no winner and the lock falls away on the next edge.
   always_comb begin
      win_vld = 1'b0;
      win_id  = 1'b0;
      if (lock_q) begin
         win_id  = lock_id_q;
         win_vld = vld[lock_id_q];
      end else if (vld == 2'b01) begin
         win_vld = 1'b1;
      end else if (vld == 2'b10) begin
         win_vld = 1'b1;
         win_id  = 1'b1;
      end else if (vld == 2'b11) begin
         win_vld = 1'b1;
         win_id  = prio_q;
      end
   end

   assign can_accept = !rsp_valid_q || rsp_ready_i;
   assign rdy[0]     = can_accept && win_vld && !win_id && !flush_i && rst_ni;
   assign rdy[1]     = can_accept && win_vld &&  win_id && !flush_i && rst_ni;
   assign fire       = |rdy;

   assign r0_ready_o = rdy[0];
   assign r1_ready_o = rdy[1];
   assign alu_aluc_o = win_vld ? req[win_id].aluc : 5'b00000;
   assign alu_a_o    = win_vld ? req[win_id].a    : '0;
   assign alu_b_o    = win_vld ? req[win_id].b    : '0;

   always_comb begin
      prio_d       = prio_q;
      lock_d       = 1'b0;
      lock_id_d    = lock_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      if (flush_i) begin
         rsp_valid_d = 1'b0;
      end else begin
         if (fire) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = win_id;
            rsp_result_d = alu_result_i;
            prio_d       = ~win_id;
         end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
         end
         if (win_vld && !can_accept) begin
            lock_d    = 1'b1;
            lock_id_d = win_id;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q       <= PRIO_RESET;
         lock_q       <= 1'b0;
         lock_id_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         prio_q       <= prio_d;
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates one shared ALU between two requesters: r0 = execute-stage integer ops, r1 = secondary user such as address-gen or branch compare.
- Sits between the decode/alu_control output (5-bit ALU control code plus operands) and the single ALU instance.
- Round-robin grant with a stall lock, a registered 1-entry response buffer tagged with requester ID, and valid/ready on both sides.

Parameters:
- XLEN, 32, operand/result width.
- PRIO_RESET, 0, requester holding priority after reset (0 or 1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- flush_i  input  1  synchronous pipeline flush.
- r0_valid_i  input  1  requester 0 has an op.
- r0_ready_o  output  1  requester 0 op accepted this cycle.
- r0_aluc_i  input  5  requester 0 ALU control code.
- r0_a_i  input  XLEN  requester 0 operand A.
- r0_b_i  input  XLEN  requester 0 operand B.
- r1_valid_i, r1_ready_o, r1_aluc_i, r1_a_i, r1_b_i: same as r0, for requester 1.
- alu_aluc_o  output  5  control code to the ALU.
- alu_a_o  output  XLEN  operand A to the ALU.
- alu_b_o  output  XLEN  operand B to the ALU.
- alu_result_i  input  XLEN  combinational ALU result.
- rsp_valid_o  output  1  response buffer holds a result.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_id_o  output  1  requester that owns the response.
- rsp_result_o  output  XLEN  registered ALU result.

Behaviour:
- State:
  - prio_q (1b): requester that wins a tie.
  - lock_q (1b valid) plus lock_id_q (1b).
  - Response register: rsp_valid_o, rsp_id_o, rsp_result_o.
- Winner selection (combinational):
  - If lock_q is set, winner = lock_id_q.
  - Else if only one valid, that one wins.
  - Else if both valid, prio_q wins.
  - Else no winner.
- Lock: if a winner exists but can_accept = 0, set lock_q and store the winner in lock_id_q. Clear lock_q when that requester fires.
  - This prevents the grant switching away from a stalled request.
- can_accept = !rsp_valid_o || rsp_ready_i.
  - The buffer is pass-through: it accepts in the same cycle the old response drains.
- rX_ready_o = can_accept && winner==X && !flush_i && rst_ni. At most one ready is high per cycle.
- ALU drive:
  - alu_* = the winner's aluc/a/b whenever a winner exists, regardless of ready.
  - With no winner, drive aluc=5'b00000, a=0, b=0.
  - aluc is opaque: no decoding. 5'b11111 and undefined codes pass through unchanged.
- Fire (valid && ready) on X, next edge:
  - rsp_valid_o=1, rsp_id_o=X, rsp_result_o=alu_result_i.
  - prio_q=~X.
  - Latency is exactly 1 cycle from fire to rsp_valid_o.
- Response drain: rsp_valid_o && rsp_ready_i with no fire -> rsp_valid_o=0. With a simultaneous fire, the buffer reloads with the new result and stays valid.
- Stall: while rsp_valid_o && !rsp_ready_i, rsp_id_o and rsp_result_o hold stable.
- Requester protocol: requesters hold aluc/a/b stable while valid && !ready. The arbiter does not latch operands before fire.
- flush_i at a clock edge:
  - rsp_valid_o=0, lock_q=0. No fire occurs that cycle (readies forced low).
  - prio_q, rsp_id_o and rsp_result_o are unchanged.
  - If flush_i and rsp_ready_i are both high, no response is counted as delivered beyond what the consumer saw.
- Reset (rst_ni=0 at an edge):
  - rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, prio_q=PRIO_RESET, lock_q=0, lock_id_q=0.
  - r0_ready_o and r1_ready_o are 0 while rst_ni=0.
  - Reset mid-stall discards the locked request and the buffered response.
- Deassertion of a valid while locked (protocol violation): lock_q clears the next cycle and arbitration resumes normally.

Test Plan:
- Reset then idle: rst_ni low 2 cycles, PRIO_RESET=0 -> rsp_valid_o=0, both readies 0, alu_aluc_o=0.
- Single requester: r0 valid aluc=5'b00000, a=5, b=7, ALU model returns 12, rsp_ready_i=1 -> r0_ready_o=1 the same cycle; next cycle rsp_valid_o=1, rsp_id_o=0, rsp_result_o=12.
- Contention round-robin: both valid continuously, rsp_ready_i=1 -> grants alternate r0,r1,r0,r1; rsp_id_o sequence 0,1,0,1 with one result per cycle.
- Backpressure lock: rsp_valid_o=1, rsp_ready_i=0, prio_q=1, r0 valid then r1 valid one cycle later -> r0 stays winner (alu_a_o = r0_a_i), r1_ready_o stays 0. When rsp_ready_i rises, r0 fires in that cycle and r1 fires the following cycle.
- Flush mid-stall: buffered result pending, lock on r1, flush_i pulse -> next cycle rsp_valid_o=0, lock cleared, prio_q unchanged, no fire during the flush cycle.
- Simultaneous drain and fire: rsp_valid_o=1, rsp_ready_i=1, r1 valid -> r1 fires, rsp_valid_o stays 1 with new rsp_id_o=1 and the new result.
